// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command assembler
package uart_cmd_pkg;

    // Frame position: which byte of the 3-byte frame is expected next.
    typedef enum logic [1:0] {
        WAIT_CMD,
        WAIT_HI,
        WAIT_LO
    } asm_state_t;

    localparam int FRAME_BYTES     = 3;
    localparam int DEFAULT_TIMEOUT = 50000;

endpackage

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - assembles 3-byte UART frames into cmd + 16-bit operand
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx_data[7:0] received byte from the UART receiver
//   rdy          receiver byte-valid, held until acknowledged
//   clr_rdy      registered one-cycle acknowledge to the receiver
//   clr_cmd_rdy  consumer acknowledge, clears cmd_rdy
//   cmd[7:0]     command byte of the last completed frame
//   data[15:0]   operand of the last completed frame, {byte1, byte2}
//   cmd_rdy      sticky frame-complete flag
//   frame_err    one-cycle pulse when a partial frame is dropped on timeout
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rdy,
    output logic        clr_rdy,
    input  logic        clr_cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    asm_state_t    state;
    asm_state_t    state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    cmd_sh;
    logic [7:0]    hi_sh;

    logic acc;
    logic tmo;
    logic cap_cmd;
    logic cap_hi;
    logic complete;

    // The receiver keeps rdy high for one more edge after seeing clr_rdy;
    // masking with clr_rdy stops that edge from taking the byte twice.
    assign acc = rdy & ~clr_rdy;

    // Expiry on the TIMEOUT-th non-accepting edge after the last accept.
    // An accept on that same edge wins.
    assign tmo = (state != WAIT_CMD) && !acc && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_CMD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_cmd   = 1'b0;
        cap_hi    = 1'b0;
        complete  = 1'b0;
        case (state)
            WAIT_CMD: begin
                if (acc) begin
                    cap_cmd   = 1'b1;
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (acc) begin
                    cap_hi    = 1'b1;
                    state_nxt = WAIT_LO;
                end else if (tmo) begin
                    state_nxt = WAIT_CMD;
                end
            end
            WAIT_LO: begin
                if (acc) begin
                    complete  = 1'b1;
                    state_nxt = WAIT_CMD;
                end else if (tmo) begin
                    state_nxt = WAIT_CMD;
                end
            end
            default: state_nxt = WAIT_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            cmd_sh    <= '0;
            hi_sh     <= '0;
            clr_rdy   <= 1'b0;
            frame_err <= 1'b0;
            cmd       <= '0;
            data      <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            clr_rdy   <= acc;
            frame_err <= tmo;

            if (acc || tmo || (state == WAIT_CMD)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (tmo) begin
                cmd_sh <= '0;
                hi_sh  <= '0;
            end else begin
                if (cap_cmd) cmd_sh <= rx_data;
                if (cap_hi)  hi_sh  <= rx_data;
            end

            // Outputs move only on completion; a partial or dropped frame
            // leaves the previous result visible.
            if (complete) begin
                cmd  <= cmd_sh;
                data <= {hi_sh, rx_data};
            end

            // Set has priority over the consumer's clear on the same edge.
            if (complete) begin
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || cap_cmd) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - directed self-checking bench for uart_cmd_assembler
module tb_uart_cmd_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rdy;
    logic        clr_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int clr_cnt = 0;
    int fe_cnt = 0;
    int clr_base;
    int fe_base;

    uart_cmd_assembler #(.TIMEOUT(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rdy         (rdy),
        .clr_rdy     (clr_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_rdy === 1'b1)   clr_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Receiver model: hold rdy until clr_rdy is seen, then drop it one edge later.
    // Returns one edge after the accept edge with rdy low.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        rx_data = b;
        rdy = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            step(1);
            if (clr_rdy === 1'b1) got = 1'b1;
        end
        check("byte_accepted", {31'd0, got}, 32'd1);
        step(1);
        rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rx_data = 8'h00;
        rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        check("rst_clr_rdy",   {31'd0, clr_rdy},   32'd0);
        check("rst_cmd",       {24'd0, cmd},       32'h00);
        check("rst_data",      {16'd0, data},      32'h0000);
        check("rst_cmd_rdy",   {31'd0, cmd_rdy},   32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);

        // Basic frame
        clr_base = clr_cnt;
        fe_base  = fe_cnt;
        send_byte(8'h05);
        send_byte(8'hA5);
        check("partial_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        send_byte(8'h3C);
        step(2);
        check("basic_cmd",     {24'd0, cmd},  32'h05);
        check("basic_data",    {16'd0, data}, 32'hA53C);
        check("basic_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("basic_clr_pulses", clr_cnt - clr_base, 32'd3);
        check("basic_no_ferr",    fe_cnt - fe_base,   32'd0);

        // Second frame, then consumer acknowledge
        send_byte(8'h02);
        send_byte(8'hFF);
        send_byte(8'h00);
        check("lb_cmd",  {24'd0, cmd},  32'h02);
        check("lb_data", {16'd0, data}, 32'hFF00);
        check("lb_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        clr_cmd_rdy = 1'b1;
        step(1);
        clr_cmd_rdy = 1'b0;
        check("ack_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("ack_cmd",  {24'd0, cmd},  32'h02);
        check("ack_data", {16'd0, data}, 32'hFF00);
        clr_cmd_rdy = 1'b1;
        step(1);
        clr_cmd_rdy = 1'b0;
        check("ack_idle_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);

        // Timeout resync: 8'h22 accepted at E0; send_byte returns at E1+1
        fe_base = fe_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        step(18);
        check("tmo_ferr_e19", {31'd0, frame_err}, 32'd0);
        step(1);
        check("tmo_ferr_e20", {31'd0, frame_err}, 32'd1);
        step(1);
        check("tmo_ferr_e21", {31'd0, frame_err}, 32'd0);
        step(4);
        check("tmo_single_pulse", fe_cnt - fe_base, 32'd1);
        check("tmo_cmd_hold",  {24'd0, cmd},  32'h02);
        check("tmo_data_hold", {16'd0, data}, 32'hFF00);
        check("tmo_cmd_rdy",   {31'd0, cmd_rdy}, 32'd0);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        check("resync_cmd",  {24'd0, cmd},  32'h33);
        check("resync_data", {16'd0, data}, 32'h4455);
        check("resync_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

        // Edge of window: second byte accepted on edge 20 after the first
        fe_base = fe_cnt;
        send_byte(8'h66);
        step(18);
        rx_data = 8'h77;
        rdy = 1'b1;
        step(1);
        check("edge_accepted",  {31'd0, clr_rdy},   32'd1);
        check("edge_no_ferr",   {31'd0, frame_err}, 32'd0);
        step(1);
        rdy = 1'b0;
        check("edge_no_ferr2",  {31'd0, frame_err}, 32'd0);
        send_byte(8'h88);
        check("edge_cmd",  {24'd0, cmd},  32'h66);
        check("edge_data", {16'd0, data}, 32'h7788);
        check("edge_ferr_count", fe_cnt - fe_base, 32'd0);

        // clr_cmd_rdy on the completion edge: set wins
        send_byte(8'hA1);
        send_byte(8'hB2);
        rx_data = 8'hC3;
        rdy = 1'b1;
        clr_cmd_rdy = 1'b1;
        step(1);
        clr_cmd_rdy = 1'b0;
        check("simul_accepted", {31'd0, clr_rdy}, 32'd1);
        check("simul_cmd_rdy",  {31'd0, cmd_rdy}, 32'd1);
        check("simul_data",     {16'd0, data},    32'hB2C3);
        step(1);
        rdy = 1'b0;

        // New byte 0 while cmd_rdy set: flag clears, outputs hold
        send_byte(8'hD4);
        check("newf_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("newf_cmd",  {24'd0, cmd},  32'hA1);
        check("newf_data", {16'd0, data}, 32'hB2C3);
        send_byte(8'hE5);
        check("newf_cmd_hold", {24'd0, cmd}, 32'hA1);
        send_byte(8'hF6);
        check("newf_done_cmd",  {24'd0, cmd},  32'hD4);
        check("newf_done_data", {16'd0, data}, 32'hE5F6);

        // Reset mid-frame
        send_byte(8'h07);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_cmd",     {24'd0, cmd},  32'h00);
        check("mrst_data",    {16'd0, data}, 32'h0000);
        check("mrst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("mrst_clr_rdy", {31'd0, clr_rdy}, 32'd0);
        check("mrst_ferr",    {31'd0, frame_err}, 32'd0);
        send_byte(8'h09);
        send_byte(8'h12);
        check("mrst_partial_rdy", {31'd0, cmd_rdy}, 32'd0);
        send_byte(8'h34);
        check("mrst_new_cmd",  {24'd0, cmd},  32'h09);
        check("mrst_new_data", {16'd0, data}, 32'h1234);
        check("mrst_new_rdy",  {31'd0, cmd_rdy}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
